// File: rtl/riscv_tb_pkg.sv
// Shared types and instruction encodings for the RISC-V run controller.
package riscv_tb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST_HOLD,
        RUN,
        HALTED,
        TIMEOUT
    } run_state_t;

    localparam logic [31:0] INSN_ECALL    = 32'h00000073;
    localparam logic [31:0] INSN_JAL_SELF = 32'h0000006F;

endpackage

// File: rtl/trace_ring_buffer.sv
// Circular trace store: wrapping write pointer, saturating valid count,
// registered read indexed back from the newest entry.
module trace_ring_buffer #(
    parameter int unsigned W     = 96,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   valid
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned VAL_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Newest entry sits just behind the write pointer.
    assign rd_ptr = wr_ptr - PTR_W'(1) - rd_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            valid   <= '0;
            rd_data <= '0;
        end else begin
            rd_data <= ({1'b0, rd_idx} < valid) ? mem[rd_ptr] : '0;
            if (clr) begin
                wr_ptr <= '0;
                valid  <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (valid != VAL_W'(DEPTH)) begin
                    valid <= valid + VAL_W'(1);
                end
            end
        end
    end

    // Storage needs no reset; the valid count masks stale entries.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/riscv_run_controller.sv
// Core run controller: reset sequencing, halt/timeout detection, run counters
// and a trace of recently retired instructions.
module riscv_run_controller
    import riscv_tb_pkg::*;
#(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned RST_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned TRACE_DEPTH    = 16,
    parameter logic [31:0] HALT_INSN      = INSN_ECALL,
    parameter bit          LOOP_HALT      = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           soft_rst_req,
    input  logic [XLEN-1:0]                core_pc,
    input  logic [31:0]                    core_instr,
    input  logic                           core_retire,
    output logic                           core_reset,
    output logic                           running,
    output logic                           halted,
    output logic                           timed_out,
    output logic [XLEN-1:0]                halt_pc,
    output logic [CNT_W-1:0]               cycle_count,
    output logic [CNT_W-1:0]               retired_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
    output logic [XLEN-1:0]                trace_rd_pc,
    output logic [31:0]                    trace_rd_instr,
    output logic [$clog2(TRACE_DEPTH):0]   trace_valid
);

    localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned TW     = XLEN + 32;

    run_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [XLEN-1:0]   last_pc;
    logic              halt_det;
    logic              timeout_det;
    logic              restart;
    logic              trace_wr;
    logic [TW-1:0]     trace_rd_data;

    // Halt/timeout detection and restart decode for the current cycle.
    always_comb begin
        halt_det    = 1'b0;
        timeout_det = 1'b0;
        restart     = 1'b0;
        halt_det    = core_retire && ((core_instr == HALT_INSN) ||
                      (LOOP_HALT && (retired_count != '0) && (core_pc == last_pc)));
        timeout_det = (TIMEOUT_CYCLES != 0) &&
                      (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1)) && !halt_det;
        restart     = (soft_rst_req && (state != IDLE)) ||
                      (start && ((state == IDLE) || (state == HALTED) || (state == TIMEOUT)));
    end

    assign trace_wr = (state == RUN) && core_retire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            core_reset    <= 1'b1;
            running       <= 1'b0;
            halted        <= 1'b0;
            timed_out     <= 1'b0;
            halt_pc       <= '0;
            cycle_count   <= '0;
            retired_count <= '0;
            last_pc       <= '0;
            hold_cnt      <= '0;
        end else if (restart) begin
            state         <= RST_HOLD;
            core_reset    <= 1'b1;
            running       <= 1'b0;
            halted        <= 1'b0;
            timed_out     <= 1'b0;
            halt_pc       <= '0;
            cycle_count   <= '0;
            retired_count <= '0;
            hold_cnt      <= '0;
        end else begin
            case (state)
                RST_HOLD: begin
                    if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                        running    <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                    if (core_retire) begin
                        last_pc <= core_pc;
                        if (retired_count != '1) begin
                            retired_count <= retired_count + CNT_W'(1);
                        end
                    end
                    if (halt_det) begin
                        state      <= HALTED;
                        halted     <= 1'b1;
                        running    <= 1'b0;
                        core_reset <= 1'b1;
                        halt_pc    <= core_pc;
                    end else if (timeout_det) begin
                        state      <= TIMEOUT;
                        timed_out  <= 1'b1;
                        running    <= 1'b0;
                        core_reset <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    trace_ring_buffer #(
        .W     (TW),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (restart),
        .wr_en   (trace_wr),
        .wr_data ({core_pc, core_instr}),
        .rd_idx  (trace_rd_idx),
        .rd_data (trace_rd_data),
        .valid   (trace_valid)
    );

    assign trace_rd_pc    = trace_rd_data[TW-1:32];
    assign trace_rd_instr = trace_rd_data[31:0];

endmodule

// File: tb/tb_riscv_run_controller.sv
// Self-checking bench for riscv_run_controller with a trace scoreboard.
module tb_riscv_run_controller;
    import riscv_tb_pkg::*;

    localparam int          XLEN  = 64;
    localparam int          CNT_W = 32;
    localparam int          DEPTH = 16;
    localparam int unsigned IDX_W = 4;
    localparam int          TMO   = 24;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             soft_rst_req = 1'b0;
    logic [XLEN-1:0]  core_pc = '0;
    logic [31:0]      core_instr = '0;
    logic             core_retire = 1'b0;
    logic             core_reset;
    logic             running;
    logic             halted;
    logic             timed_out;
    logic [XLEN-1:0]  halt_pc;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retired_count;
    logic [IDX_W-1:0] trace_rd_idx = '0;
    logic [XLEN-1:0]  trace_rd_pc;
    logic [31:0]      trace_rd_instr;
    logic [IDX_W:0]   trace_valid;

    always #5 clk = ~clk;

    riscv_run_controller #(
        .XLEN           (XLEN),
        .CNT_W          (CNT_W),
        .RST_CYCLES     (2),
        .TIMEOUT_CYCLES (TMO),
        .TRACE_DEPTH    (DEPTH),
        .HALT_INSN      (INSN_ECALL),
        .LOOP_HALT      (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .soft_rst_req   (soft_rst_req),
        .core_pc        (core_pc),
        .core_instr     (core_instr),
        .core_retire    (core_retire),
        .core_reset     (core_reset),
        .running        (running),
        .halted         (halted),
        .timed_out      (timed_out),
        .halt_pc        (halt_pc),
        .cycle_count    (cycle_count),
        .retired_count  (retired_count),
        .trace_rd_idx   (trace_rd_idx),
        .trace_rd_pc    (trace_rd_pc),
        .trace_rd_instr (trace_rd_instr),
        .trace_valid    (trace_valid)
    );

    int total = 0;
    int bad   = 0;
    logic [95:0] model[$];
    logic [95:0] sb_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_valid();
        return (model.size() > DEPTH) ? DEPTH : model.size();
    endfunction

    function automatic logic [95:0] model_entry(input int idx);
        if (idx < model_valid()) return model[model.size() - 1 - idx];
        return '0;
    endfunction

    // Retire one instruction in RUN; the model records it in the trace.
    task automatic retire(input logic [63:0] pc, input logic [31:0] ins);
        core_retire = 1'b1;
        core_pc     = pc;
        core_instr  = ins;
        tick();
        core_retire = 1'b0;
        model.push_back({pc, ins});
    endtask

    task automatic trace_read(input int idx);
        logic [95:0] exp;
        trace_rd_idx = IDX_W'(idx);
        sb_q.push_back(model_entry(idx));
        tick();
        exp = sb_q.pop_front();
        check($sformatf("trace_idx%0d", idx), {32'h0, trace_rd_pc, trace_rd_instr}, {32'h0, exp});
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model.delete();
    endtask

    task automatic check_counts(input string tag, input int cyc, input int ret);
        check({tag, "_cycles"}, 128'(cycle_count), 128'(cyc));
        check({tag, "_retired"}, 128'(retired_count), 128'(ret));
        check({tag, "_tvalid"}, 128'(trace_valid), 128'(model_valid()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_core_reset", 128'(core_reset), 128'(1));
        check("rst_running", 128'(running), 128'(0));
        check("rst_halted", 128'(halted), 128'(0));
        check("rst_timed_out", 128'(timed_out), 128'(0));
        check("rst_halt_pc", 128'(halt_pc), 128'(0));
        check_counts("rst", 0, 0);
        reset = 1'b1;
        tick();

        // Start: core_reset held exactly two clocks
        do_start();
        check("s1_core_reset_a", 128'(core_reset), 128'(1));
        check("s1_running_a", 128'(running), 128'(0));
        tick();
        check("s1_core_reset_b", 128'(core_reset), 128'(1));
        tick();
        check("s1_core_reset_c", 128'(core_reset), 128'(0));
        check("s1_running_c", 128'(running), 128'(1));

        // Short program ending in ecall
        retire(64'd0, NOP);
        retire(64'd4, NOP);
        retire(64'd8, NOP);
        check("s2_not_halted", 128'(halted), 128'(0));
        retire(64'd12, INSN_ECALL);
        check("s2_halted", 128'(halted), 128'(1));
        check("s2_running", 128'(running), 128'(0));
        check("s2_core_reset", 128'(core_reset), 128'(1));
        check("s2_halt_pc", 128'(halt_pc), 128'(12));
        check_counts("s2", 4, 4);
        trace_read(0);
        check("s2_idx0_literal", {64'h0, trace_rd_pc[31:0], trace_rd_instr}, {64'h0, 32'd12, 32'h73});
        trace_read(3);
        trace_read(1);
        trace_read(4);
        check_counts("s2_held", 4, 4);

        // Trace wrap with 20 retires, then timeout
        do_start();
        check_counts("s4_clr", 0, 0);
        check("s4_halted_clr", 128'(halted), 128'(0));
        tick();
        tick();
        for (int i = 0; i < 20; i++) retire(64'(4 * i), NOP);
        check_counts("s4", 20, 20);
        trace_read(15);
        check("s4_idx15_pc", 128'(trace_rd_pc), 128'(16));
        trace_read(0);
        check("s4_idx0_pc", 128'(trace_rd_pc), 128'(76));
        trace_read(8);
        for (int i = 0; i < 50 && !timed_out; i++) tick();
        check("s3_timed_out", 128'(timed_out), 128'(1));
        check("s3_running", 128'(running), 128'(0));
        check("s3_core_reset", 128'(core_reset), 128'(1));
        check_counts("s3", TMO, 20);
        tick();
        check_counts("s3_held", TMO, 20);
        trace_read(0);

        // Gaps in retire, then a self-loop halt
        do_start();
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) retire(64'(2 * i), NOP);
            else tick();
        end
        check_counts("s5", 10, 5);
        check("s5_running", 128'(running), 128'(1));
        retire(64'd100, NOP);
        check("s5_no_halt", 128'(halted), 128'(0));
        retire(64'd100, INSN_JAL_SELF);
        check("s5_loop_halted", 128'(halted), 128'(1));
        check("s5_halt_pc", 128'(halt_pc), 128'(100));
        check_counts("s5_halt", 12, 7);
        trace_read(0);
        trace_read(6);

        // Soft reset mid-run, start ignored in RUN, async reset
        do_start();
        tick();
        tick();
        retire(64'h200, NOP);
        retire(64'h204, NOP);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s6_start_in_run", 128'(running), 128'(1));
        check_counts("s6_pre", 3, 2);
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        model.delete();
        check("s6_soft_core_reset_a", 128'(core_reset), 128'(1));
        check("s6_soft_running", 128'(running), 128'(0));
        check_counts("s6_soft", 0, 0);
        trace_read(0);
        check("s6_soft_core_reset_b", 128'(core_reset), 128'(1));
        tick();
        check("s6_soft_core_reset_c", 128'(core_reset), 128'(0));
        check("s6_soft_running_c", 128'(running), 128'(1));
        retire(64'h300, NOP);
        retire(64'h304, NOP);
        trace_read(0);
        #2;
        reset = 1'b0;
        #1;
        check("s6_async_running", 128'(running), 128'(0));
        check("s6_async_core_reset", 128'(core_reset), 128'(1));
        check("s6_async_trace_pc", 128'(trace_rd_pc), 128'(0));
        model.delete();
        check_counts("s6_async", 0, 0);
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
